// File: rtl/riscv_pkg.sv
// RISC-V architectural types shared across the tortoise core:
// privilege levels and the base opcode map.
package riscv_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

endpackage

// File: rtl/tortoise_pkg.sv
// Tortoise pipeline types: fetch entries, scoreboard entries and
// decode-buffer sizing defaults.
package tortoise_pkg;

    localparam int unsigned INSTR_PER_FETCH  = 2;
    localparam int unsigned DECODE_BUF_DEPTH = 8;
    localparam int unsigned ISSUE_WIDTH      = 2;

    typedef logic [$clog2(DECODE_BUF_DEPTH+1)-1:0] decode_cnt_t;

    typedef enum logic [2:0] {
        FU_NONE, FU_ALU, FU_MULT, FU_BRANCH,
        FU_LOAD, FU_STORE, FU_CSR
    } fu_t;

    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_FETCH_PF = 4'd12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        page_fault;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ex_valid;
        logic [3:0]  cause;
    } scoreboard_entry_t;

endpackage

// File: rtl/decode_fifo.sv
// In-order circular store of scoreboard entries with multi-push,
// multi-pop and a head window of NR_POP entries.
module decode_fifo
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH   = DECODE_BUF_DEPTH,
    parameter int unsigned NR_PUSH = INSTR_PER_FETCH,
    parameter int unsigned NR_POP  = ISSUE_WIDTH
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic [$clog2(NR_PUSH+1)-1:0]       push_cnt_i,
    input  scoreboard_entry_t [NR_PUSH-1:0]    push_data_i,
    input  logic [$clog2(NR_POP+1)-1:0]        pop_cnt_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o,
    output scoreboard_entry_t [NR_POP-1:0]     head_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    scoreboard_entry_t mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + PW'(pop_cnt_i);
            wr_ptr_q <= wr_ptr_q + PW'(push_cnt_i);
            count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            for (int j = 0; j < NR_PUSH; j++) begin
                if (j < int'(push_cnt_i))
                    mem_q[wr_ptr_q + PW'(j)] <= push_data_i[j];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NR_POP; k++)
            head_o[k] = mem_q[rd_ptr_q + PW'(k)];
    end

    assign count_o = count_q;

endmodule

// File: rtl/decoder.sv
// Single-lane combinational RV32IM decoder producing a scoreboard entry,
// including privilege-dependent illegal-instruction detection.
module decoder
    import tortoise_pkg::*;
    import riscv_pkg::*;
(
    input  fetch_entry_t      fetch_i,
    input  logic              debug_mode_i,
    input  priv_lvl_t         priv_lvl_i,
    input  logic              tvm_i,
    input  logic              tw_i,
    input  logic              tsr_i,
    output scoreboard_entry_t instr_o
);
    logic [31:0] ir;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [11:0] f12;
    logic [1:0]  priv;
    logic        is_s;
    logic        sys_illegal;
    logic        illegal;

    assign ir   = fetch_i.instr;
    assign opc  = ir[6:0];
    assign f3   = ir[14:12];
    assign f12  = ir[31:20];
    assign priv = priv_lvl_i;
    assign is_s = (priv_lvl_i == PRIV_LVL_S);

    always_comb begin
        sys_illegal = 1'b0;
        if (f3 != 3'b000) begin
            // CSR access: reserved funct3, privilege too low, or satp under TVM
            sys_illegal = (f3 == 3'b100) | (priv < f12[9:8])
                        | (tvm_i & is_s & (f12 == 12'h180));
        end else if (ir[31:25] == 7'b0001001) begin
            sys_illegal = (priv_lvl_i == PRIV_LVL_U) | (tvm_i & is_s);
        end else begin
            case (f12)
                12'h000, 12'h001: sys_illegal = 1'b0;
                12'h105: sys_illegal = tw_i & (priv_lvl_i != PRIV_LVL_M);
                12'h102: sys_illegal = (priv_lvl_i == PRIV_LVL_U) | (tsr_i & is_s);
                12'h302: sys_illegal = (priv_lvl_i != PRIV_LVL_M);
                12'h7b2: sys_illegal = ~debug_mode_i;
                default: sys_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        instr_o     = '0;
        instr_o.pc  = fetch_i.pc;
        instr_o.rd  = ir[11:7];
        instr_o.rs1 = ir[19:15];
        instr_o.rs2 = ir[24:20];
        illegal     = 1'b0;
        unique case (1'b1)
            opc == OPC_OP: instr_o.fu = ir[25] ? FU_MULT : FU_ALU;
            opc == OPC_OP_IMM: begin
                instr_o.fu  = FU_ALU;
                instr_o.imm = {{20{ir[31]}}, ir[31:20]};
            end
            opc == OPC_LUI, opc == OPC_AUIPC: begin
                instr_o.fu  = FU_ALU;
                instr_o.imm = {ir[31:12], 12'b0};
            end
            opc == OPC_JAL: begin
                instr_o.fu  = FU_BRANCH;
                instr_o.imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            opc == OPC_JALR: begin
                instr_o.fu  = FU_BRANCH;
                instr_o.imm = {{20{ir[31]}}, ir[31:20]};
            end
            opc == OPC_BRANCH: begin
                instr_o.fu  = FU_BRANCH;
                instr_o.imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            opc == OPC_LOAD: begin
                instr_o.fu  = FU_LOAD;
                instr_o.imm = {{20{ir[31]}}, ir[31:20]};
            end
            opc == OPC_STORE: begin
                instr_o.fu  = FU_STORE;
                instr_o.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            opc == OPC_SYSTEM: begin
                instr_o.fu = FU_CSR;
                illegal    = sys_illegal;
            end
            default: illegal = 1'b1;
        endcase
        instr_o.ex_valid = fetch_i.page_fault | illegal;
        if (fetch_i.page_fault)
            instr_o.cause = CAUSE_FETCH_PF;
        else if (illegal)
            instr_o.cause = CAUSE_ILLEGAL;
    end

endmodule

// File: rtl/decode_buffer.sv
// Multi-issue decode stage: NR_FETCH decoders feeding an in-order queue.
// Define TORTOISE_DECODE_BYPASS_EN for zero-latency issue when empty.
module decode_buffer
    import tortoise_pkg::*;
    import riscv_pkg::*;
#(
    parameter int unsigned NR_FETCH = INSTR_PER_FETCH,
    parameter int unsigned NR_ISSUE = ISSUE_WIDTH,
    parameter int unsigned DEPTH    = DECODE_BUF_DEPTH
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              debug_mode_i,
    input  priv_lvl_t                         priv_lvl_i,
    input  logic                              tvm_i,
    input  logic                              tw_i,
    input  logic                              tsr_i,
    input  logic                              fetch_valid_i,
    output logic                              fetch_pop_o,
    input  fetch_entry_t [NR_FETCH-1:0]       fetch_i,
    output logic [NR_ISSUE-1:0]               issue_valid_o,
    output scoreboard_entry_t [NR_ISSUE-1:0]  issue_instr_o,
    input  logic [$clog2(NR_ISSUE+1)-1:0]     issue_pop_cnt_i
);
    localparam int unsigned CW    = $clog2(DEPTH+1);
    localparam int unsigned IW    = $clog2(NR_ISSUE+1);
    localparam int unsigned FW    = $clog2(NR_FETCH+1);
    localparam int unsigned BYP_N = (NR_FETCH < NR_ISSUE) ? NR_FETCH : NR_ISSUE;

    scoreboard_entry_t [NR_FETCH-1:0] dec;
    scoreboard_entry_t [NR_FETCH-1:0] push_data;
    scoreboard_entry_t [NR_ISSUE-1:0] head;
    logic [CW-1:0] count;
    logic [IW-1:0] avail;
    logic [IW-1:0] pops;
    logic [IW-1:0] fifo_pops;
    logic [IW-1:0] skip;
    logic [FW-1:0] push_cnt;
    logic          bypass;

    for (genvar i = 0; i < NR_FETCH; i++) begin : g_dec
        decoder u_dec (
            .fetch_i      (fetch_i[i]),
            .debug_mode_i (debug_mode_i),
            .priv_lvl_i   (priv_lvl_i),
            .tvm_i        (tvm_i),
            .tw_i         (tw_i),
            .tsr_i        (tsr_i),
            .instr_o      (dec[i])
        );
    end

    // acceptance uses registered occupancy only: no issue-to-fetch path
    assign fetch_pop_o = fetch_valid_i & ~flush_i
                       & ((CW'(DEPTH) - count) >= CW'(NR_FETCH));

`ifdef TORTOISE_DECODE_BYPASS_EN
    assign bypass = fetch_valid_i & ~flush_i & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        if (bypass)
            avail = IW'(BYP_N);
        else if (count >= CW'(NR_ISSUE))
            avail = IW'(NR_ISSUE);
        else
            avail = IW'(count);
        pops = (issue_pop_cnt_i > avail) ? avail : issue_pop_cnt_i;
        if (flush_i)
            pops = '0;
        fifo_pops = bypass ? '0 : pops;
        skip      = bypass ? pops : '0;
        push_cnt  = '0;
        if (fetch_pop_o)
            push_cnt = FW'(NR_FETCH) - FW'(skip);
        // lanes consumed by bypass are dropped; the rest pack down to lane 0
        push_data = '0;
        for (int j = 0; j < NR_FETCH; j++) begin
            for (int i = 0; i < NR_FETCH; i++) begin
                if (i == j + int'(skip))
                    push_data[j] = dec[i];
            end
        end
    end

    decode_fifo #(
        .DEPTH   (DEPTH),
        .NR_PUSH (NR_FETCH),
        .NR_POP  (NR_ISSUE)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .pop_cnt_i   (fifo_pops),
        .count_o     (count),
        .head_o      (head)
    );

    always_comb begin
        for (int k = 0; k < NR_ISSUE; k++) begin
            issue_valid_o[k] = IW'(k) < avail;
            issue_instr_o[k] = head[k];
            if (bypass && k < BYP_N)
                issue_instr_o[k] = dec[k];
        end
    end

`ifndef SYNTHESIS
    pop_cnt_legal: assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i)
        issue_pop_cnt_i <= avail
    );
`endif

endmodule

// File: tb/tb_decode_buffer.sv
// Scoreboard bench for decode_buffer (NR_FETCH=2, NR_ISSUE=2, DEPTH=8).
module tb_decode_buffer;
    import tortoise_pkg::*;
    import riscv_pkg::*;

    localparam int NF = 2;
    localparam int NI = 2;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush = 1'b0;
    logic fvalid = 1'b0;
    logic [1:0] popc = '0;
    priv_lvl_t priv = PRIV_LVL_M;
    logic fpop;
    fetch_entry_t [NF-1:0] fetch;
    logic [NI-1:0] ivalid;
    scoreboard_entry_t [NI-1:0] iinstr;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] q[$];
    logic [31:0] next_pc = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            fetch[i].pc = next_pc + 32'(4 * i);
            fetch[i].instr = {next_pc[11:0] + 12'(4 * i), 5'd0, 3'b000, 5'd1, 7'h13};
            fetch[i].page_fault = 1'b0;
        end
    end

    decode_buffer #(.NR_FETCH(NF), .NR_ISSUE(NI), .DEPTH(D)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_i         (flush),
        .debug_mode_i    (1'b0),
        .priv_lvl_i      (priv),
        .tvm_i           (1'b0),
        .tw_i            (1'b0),
        .tsr_i           (1'b0),
        .fetch_valid_i   (fvalid),
        .fetch_pop_o     (fpop),
        .fetch_i         (fetch),
        .issue_valid_o   (ivalid),
        .issue_instr_o   (iinstr),
        .issue_pop_cnt_i (popc)
    );

    function automatic logic byp_cond();
`ifdef TORTOISE_DECODE_BYPASS_EN
        return q.size() == 0 && fvalid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_avail();
        if (byp_cond()) return (NF < NI) ? NF : NI;
        return (q.size() < NI) ? q.size() : NI;
    endfunction

    function automatic logic exp_fpop();
        return fvalid && !flush && (D - q.size() >= NF);
    endfunction

    function automatic logic [31:0] exp_pc(int k);
        if (byp_cond()) return next_pc + 32'(4 * k);
        return q[k];
    endfunction

    function automatic logic [NI-1:0] therm(int n);
        logic [NI-1:0] t;
        t = '0;
        for (int i = 0; i < NI; i++) if (i < n) t[i] = 1'b1;
        return t;
    endfunction

    // one clock: DUT samples at the edge, model follows afterwards
    task automatic tick();
        logic acc;
        logic byp;
        int p;
        acc = exp_fpop();
        byp = byp_cond();
        p = (int'(popc) > exp_avail()) ? exp_avail() : int'(popc);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (byp) begin
                for (int i = p; i < NF; i++) q.push_back(next_pc + 32'(4 * i));
            end else begin
                for (int i = 0; i < p; i++) void'(q.pop_front());
                if (acc) for (int i = 0; i < NF; i++) q.push_back(next_pc + 32'(4 * i));
            end
            if (acc) next_pc += 32'(4 * NF);
        end
    endtask

    task automatic do_flush();
        fvalid = 1'b0;
        popc = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (ivalid !== 2'b00) $display("FAIL reset_valid got=%b exp=00", ivalid);
        if (ivalid !== 2'b00) n_fail++;
        n_checks++;
        if (fpop !== 1'b0) begin
            $display("FAIL reset_pop got=%b exp=0", fpop); n_fail++;
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        fvalid = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        fvalid = 1'b0;
        #1;
        n_checks++;
        if (ivalid !== therm(exp_avail()) || q.size() != 6) begin
            $display("FAIL pre_reset_valid got=%b exp=%b", ivalid, therm(exp_avail())); n_fail++;
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (ivalid !== 2'b00) begin
            $display("FAIL async_reset_valid got=%b exp=00", ivalid); n_fail++;
        end
        n_checks++;
        if (fpop !== 1'b0) begin
            $display("FAIL async_reset_pop got=%b exp=0", fpop); n_fail++;
        end
        q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        next_pc = 32'h100;
        fvalid = 1'b1;
        #1;
        n_checks++;
        if (fpop !== 1'b1) begin
            $display("FAIL post_reset_accept got=%b exp=1", fpop); n_fail++;
        end
        tick();
        fvalid = 1'b0;
        #1;
        n_checks++;
        if (ivalid !== 2'b11) begin
            $display("FAIL post_reset_visible got=%b exp=11", ivalid); n_fail++;
        end
        n_checks++;
        if (iinstr[0].pc !== 32'h100 || iinstr[1].pc !== 32'h104) begin
            $display("FAIL post_reset_pc got=%h/%h exp=100/104", iinstr[0].pc, iinstr[1].pc);
            n_fail++;
        end
    endtask

    task automatic test_fill();
        do_flush();
        next_pc = 32'h200;
        fvalid = 1'b1;
        popc = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if (fpop !== (c < 4) || fpop !== exp_fpop()) begin
                $display("FAIL fill_pop cycle=%0d got=%b exp=%b", c, fpop, c < 4); n_fail++;
            end
            tick();
        end
        popc = 2'd1;
        #1;
        n_checks++;
        if (fpop !== 1'b0) begin
            $display("FAIL full_pop1 got=%b exp=0", fpop); n_fail++;
        end
        tick();
        #1;
        n_checks++;
        if (fpop !== 1'b0) begin
            $display("FAIL space1_pop got=%b exp=0", fpop); n_fail++;
        end
        n_checks++;
        if (iinstr[0].pc !== 32'h204 || iinstr[0].pc !== exp_pc(0)) begin
            $display("FAIL fill_head got=%h exp=204", iinstr[0].pc); n_fail++;
        end
        tick();
        popc = '0;
        #1;
        n_checks++;
        if (fpop !== 1'b1) begin
            $display("FAIL freed_accept got=%b exp=1", fpop); n_fail++;
        end
        tick();
        fvalid = 1'b0;
    endtask

    task automatic test_wrap();
        int groups;
        logic [31:0] last;
        logic first;
        groups = 0;
        last = '0;
        first = 1'b1;
        do_flush();
        next_pc = '0;
        fvalid = 1'b1;
        for (int c = 0; c < 40 && groups < 20; c++) begin
            popc = 2'((exp_avail() >= 2) ? 2 : exp_avail());
            #1;
            n_checks++;
            if (fpop !== exp_fpop()) begin
                $display("FAIL wrap_pop cycle=%0d got=%b exp=%b", c, fpop, exp_fpop()); n_fail++;
            end
            n_checks++;
            if (ivalid !== therm(exp_avail())) begin
                $display("FAIL wrap_valid cycle=%0d got=%b exp=%b", c, ivalid, therm(exp_avail()));
                n_fail++;
            end
            for (int k = 0; k < NI; k++) begin
                if (k < exp_avail()) begin
                    n_checks++;
                    if (iinstr[k].pc !== exp_pc(k) || iinstr[k].imm !== (exp_pc(k) & 32'hfff)) begin
                        $display("FAIL wrap_lane%0d cycle=%0d got=%h exp=%h", k, c, iinstr[k].pc, exp_pc(k));
                        n_fail++;
                    end
                end
            end
            if (ivalid === 2'b11) begin
                n_checks++;
                if (!(iinstr[1].pc > iinstr[0].pc && (first || iinstr[0].pc > last))) begin
                    $display("FAIL wrap_order cycle=%0d got=%h,%h after=%h", c, iinstr[0].pc, iinstr[1].pc, last);
                    n_fail++;
                end
                if (popc == 2'd2) begin
                    last = iinstr[1].pc;
                    first = 1'b0;
                end
            end
            if (exp_fpop()) groups++;
            tick();
        end
        n_checks++;
        if (groups != 20) begin
            $display("FAIL wrap_groups got=%0d exp=20", groups); n_fail++;
        end
        fvalid = 1'b0;
        popc = 2'((exp_avail() >= 2) ? 2 : exp_avail());
        tick();
        popc = '0;
    endtask

    task automatic test_partial_pop();
        do_flush();
        next_pc = 32'h0c;
        fvalid = 1'b1;
        tick();
        tick();
        fvalid = 1'b0;
        popc = 2'd1;
        tick();
        #1;
        n_checks++;
        if (ivalid !== 2'b11 || iinstr[0].pc !== 32'h10 || iinstr[1].pc !== 32'h14) begin
            $display("FAIL partial_pre got=%b %h/%h exp=11 10/14", ivalid, iinstr[0].pc, iinstr[1].pc);
            n_fail++;
        end
        tick();
        popc = '0;
        #1;
        n_checks++;
        if (iinstr[0].pc !== 32'h14 || iinstr[1].pc !== 32'h18) begin
            $display("FAIL partial_lanes got=%h/%h exp=14/18", iinstr[0].pc, iinstr[1].pc); n_fail++;
        end
        popc = 2'd2;
        tick();
        popc = '0;
        #1;
        n_checks++;
        if (ivalid !== 2'b00 || q.size() != 0) begin
            $display("FAIL partial_count got=%b exp=00", ivalid); n_fail++;
        end
    endtask

    task automatic test_flush();
        do_flush();
        next_pc = 32'h300;
        fvalid = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        flush = 1'b1;
        #1;
        n_checks++;
        if (fpop !== 1'b0) begin
            $display("FAIL flush_pop got=%b exp=0", fpop); n_fail++;
        end
        n_checks++;
        if (ivalid !== 2'b11) begin
            $display("FAIL flush_prestate got=%b exp=11", ivalid); n_fail++;
        end
        tick();
        flush = 1'b0;
        fvalid = 1'b0;
        #1;
        n_checks++;
        if (ivalid !== 2'b00) begin
            $display("FAIL flush_empty got=%b exp=00", ivalid); n_fail++;
        end
        fvalid = 1'b1;
        #1;
        n_checks++;
        if (fpop !== 1'b1) begin
            $display("FAIL flush_reaccept got=%b exp=1", fpop); n_fail++;
        end
        tick();
        fvalid = 1'b0;
        #1;
        n_checks++;
        if (iinstr[0].pc !== 32'h318 || iinstr[0].pc !== exp_pc(0)) begin
            $display("FAIL flush_head got=%h exp=318", iinstr[0].pc); n_fail++;
        end
        popc = 2'd2;
        tick();
        popc = '0;
    endtask

    task automatic test_latency();
        do_flush();
        next_pc = 32'h40;
        fvalid = 1'b1;
        popc = 2'((exp_avail() >= 2) ? 2 : exp_avail());
        #1;
`ifdef TORTOISE_DECODE_BYPASS_EN
        n_checks++;
        if (ivalid !== 2'b11 || iinstr[0].pc !== 32'h40 || iinstr[1].pc !== 32'h44) begin
            $display("FAIL bypass_same got=%b %h/%h exp=11 40/44", ivalid, iinstr[0].pc, iinstr[1].pc);
            n_fail++;
        end
        tick();
        fvalid = 1'b0;
        popc = '0;
        #1;
        n_checks++;
        if (ivalid !== 2'b00) begin
            $display("FAIL bypass_count0 got=%b exp=00", ivalid); n_fail++;
        end
        next_pc = 32'h40;
        fvalid = 1'b1;
        popc = 2'd1;
        tick();
        fvalid = 1'b0;
        popc = '0;
        #1;
        n_checks++;
        if (ivalid !== 2'b01 || iinstr[0].pc !== 32'h44) begin
            $display("FAIL bypass_pop1 got=%b %h exp=01 44", ivalid, iinstr[0].pc); n_fail++;
        end
        popc = 2'd1;
        tick();
        popc = '0;
`else
        n_checks++;
        if (ivalid !== 2'b00) begin
            $display("FAIL latency_same got=%b exp=00", ivalid); n_fail++;
        end
        tick();
        fvalid = 1'b0;
        popc = 2'd1;
        #1;
        n_checks++;
        if (ivalid !== 2'b11 || iinstr[0].pc !== 32'h40) begin
            $display("FAIL latency_next got=%b %h exp=11 40", ivalid, iinstr[0].pc); n_fail++;
        end
        tick();
        popc = '0;
        #1;
        n_checks++;
        if (ivalid !== 2'b01 || iinstr[0].pc !== 32'h44) begin
            $display("FAIL latency_pop1 got=%b %h exp=01 44", ivalid, iinstr[0].pc); n_fail++;
        end
        popc = 2'd1;
        tick();
        popc = '0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_partial_pop();
        test_flush();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Multi-issue decode stage for the tortoise pipeline. Decodes one fetch group of `NR_FETCH` instructions per cycle, buffers the results in an in-order circular queue of `DEPTH` scoreboard entries, and presents up to `NR_ISSUE` oldest entries per cycle to issue. Issue may pop 0..`NR_ISSUE` entries per cycle. It sits between the fetch queue and the issue stage and replaces the single-pop decode stage.

## Interface
- `NR_FETCH`, default `tortoise_pkg::INSTR_PER_FETCH`: instructions per fetch group.
- `NR_ISSUE`, default `2`: issue lanes presented per cycle.
- `DEPTH`, default `8`: queue entries. Must be a power of 2, with `DEPTH >= NR_FETCH` and `DEPTH >= NR_ISSUE`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: discard all buffered entries.
- `debug_mode_i` in 1: forwarded to the decoders.
- `priv_lvl_i` in `riscv_pkg::priv_lvl_t`: current privilege level.
- `tvm_i`, `tw_i`, `tsr_i` in 1 each: CSR trap controls, forwarded to the decoders.
- `fetch_valid_i` in 1: fetch group available.
- `fetch_pop_o` out 1: group consumed this cycle.
- `fetch_i` in `tortoise_pkg::fetch_entry_t [NR_FETCH-1:0]`: the fetch group, lane 0 oldest.
- `issue_valid_o` out `[NR_ISSUE-1:0]`: thermometer code; lane k is valid only if lanes 0..k-1 are valid.
- `issue_instr_o` out `tortoise_pkg::scoreboard_entry_t [NR_ISSUE-1:0]`: oldest entries, lane 0 oldest.
- `issue_pop_cnt_i` in `$clog2(NR_ISSUE+1)`: number of lanes consumed this cycle, starting at lane 0.

## Operation
- **Decode:** `NR_FETCH` `decoder` instances, one per fetch lane, purely combinational.
- **Group acceptance:**
  - All-or-nothing; a group is never split.
  - `fetch_pop_o = fetch_valid_i & ~flush_i & (DEPTH - count >= NR_FETCH)`.
  - `count` is the registered occupancy; same-cycle pops do not create space (no combinational path from issue to fetch).
- **Push:** lanes are written at `wr_ptr .. wr_ptr+NR_FETCH-1`, modulo `DEPTH`, in lane order.
- **Pop:**
  - `issue_instr_o[k]` = entry at `rd_ptr+k` modulo `DEPTH`.
  - `issue_valid_o[k] = (k < count)`.
  - An edge advances `rd_ptr` by `issue_pop_cnt_i`.
- **Count update:** `count_next = count + (push ? NR_FETCH : 0) - pops`, width `$clog2(DEPTH+1)`. Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **Simultaneous push and pop:** both take effect in the same edge. Order is always preserved.
- **Illegal pop count:** `issue_pop_cnt_i` greater than the number of valid lanes is illegal. It is flagged by an assertion (simulation only), and the RTL clamps it to the valid-lane count.
- **Flush:**
  - At the edge: `count`, `rd_ptr` and `wr_ptr` are cleared.
  - In the flush cycle: `fetch_pop_o` is 0, and pops and pushes are ignored.
  - `issue_valid_o` still reflects the pre-flush state; the issue stage ignores it under flush.
- **Reset:** `count = 0`, pointers `= 0`, `issue_valid_o = 0`, `fetch_pop_o = 0` (with `fetch_valid_i` low). Entry storage is not reset.

## Timing
- **Latency, bypass off:** a group accepted at edge N is visible on `issue_valid_o` after edge N (one cycle).
- **Throughput:** one group in and up to `NR_ISSUE` entries out per cycle.
- **Full:** with `count > DEPTH - NR_FETCH`, `fetch_pop_o` stays 0 until pops free space. The first accept occurs in the cycle after the freeing pop.
- **Empty:** `issue_valid_o` is all zeros.

## Configuration
- `TORTOISE_DECODE_BYPASS_EN` **defined:**
  - When `count == 0`, `fetch_valid_i` is high and `flush_i` is low, lanes `0..min(NR_FETCH,NR_ISSUE)-1` drive `issue_instr_o` and `issue_valid_o` directly from the decoders (zero latency).
  - The popped lanes are not written; the remaining `NR_FETCH - pops` lanes are pushed starting at `wr_ptr`.
  - `fetch_pop_o` is high in this case because space is guaranteed.
- **Undefined:** all entries pass through storage, with fixed one-cycle latency.

## Structure
- **`tortoise_pkg` additions:**
  - Constants `DECODE_BUF_DEPTH` and `ISSUE_WIDTH` (parameter defaults).
  - Typedef `decode_cnt_t` for occupancy.
- **Sub-module `decode_fifo`:**
  - Parametrised multi-push/multi-pop circular storage of `scoreboard_entry_t`.
  - Holds pointers and count, takes a push group and a pop count, and exposes the head window.
- **Top-level logic:** `decode_buffer` instantiates the decoders and `decode_fifo`, and adds the acceptance and bypass logic.

## Test plan
All scenarios use `NR_FETCH=2`, `NR_ISSUE=2`, `DEPTH=8`, bypass off unless stated.
1. **Reset:** assert `rst_ni=0` mid-run with `count=6` -> immediately `issue_valid_o=2'b00`, `fetch_pop_o=0`. After release, the first group accepted appears next cycle.
2. **Fill:** `fetch_valid_i` held high, pop count 0 -> four groups accepted and `count=8`. `fetch_pop_o=0` from the 5th cycle on. Pop 1 -> still blocked (space 1). Pop 1 more -> accepted the next cycle.
3. **Wrap and order:** 20 sequential groups (PCs 0x0, 0x4, ...) with pop count 2 every cycle -> issue lanes show strictly increasing PCs across pointer wrap, and `count` stays constant at 2.
4. **Partial pop:** `count=3` holding PCs 0x10/0x14/0x18, pop 1 -> next cycle lane0=0x14, lane1=0x18, `count=2`.
5. **Flush:** `count=6`, `fetch_valid_i=1`, `flush_i=1` -> `fetch_pop_o=0` that cycle; next cycle `issue_valid_o=0` and `count=0`.
6. **Bypass (`TORTOISE_DECODE_BYPASS_EN`):**
   - Empty buffer, group with PCs 0x40/0x44, pop count 2 -> same-cycle `issue_valid_o=2'b11` and `count` remains 0.
   - Same stimulus with pop count 1 -> `count=1`, next cycle lane0=0x44.
   - Without the macro -> `issue_valid_o` rises one cycle later.
